// File: rtl/mem_stage_ctrl.sv
// Memory-stage request controller: issues one cache request per accepted load/store strobe,
// holds it until dhit, then pulses dhit_out. Build option MEM_STAGE_TIMEOUT_EN adds a REQ watchdog.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_req,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] exmem_addr,
    input  logic [31:0]       exmem_store_data,
    input  logic              dhit,
    input  logic [31:0]       dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [31:0]       dmemstore,
    output logic [31:0]       load_data,
    output logic              dhit_out,
    output logic              mem_busy,
    output logic              req_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t            state_q;
    logic              ren_q;
    logic              wen_q;
    logic              hit_out_q;
    logic              busy_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       store_q;
    logic [31:0]       load_q;

    logic              op_valid;
    logic              op_conflict;
    logic              timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    assign op_valid    = is_load ^ is_store;
    assign op_conflict = is_load & is_store;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Fires in the last REQ cycle, so DONE follows exactly TIMEOUT_CYCLES REQ cycles.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == REQ && !dhit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            hit_out_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            load_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    hit_out_q <= 1'b0;
                    if (mem_req && op_valid) begin
                        addr_q  <= exmem_addr;
                        store_q <= exmem_store_data;
                        ren_q   <= is_load;
                        wen_q   <= is_store;
                        busy_q  <= 1'b1;
                        state_q <= REQ;
                    end else if (mem_req && op_conflict) begin
                        err_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_req) begin
                        err_q <= 1'b1;
                    end
                    if (dhit || timeout) begin
                        if (dhit && ren_q) begin
                            load_q <= dmemload;
                        end
                        if (!dhit) begin
                            err_q <= 1'b1;
                        end
                        ren_q     <= 1'b0;
                        wen_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        hit_out_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (mem_req) begin
                        err_q <= 1'b1;
                    end
                    hit_out_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    ren_q     <= 1'b0;
                    wen_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    hit_out_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign dmemREN   = ren_q;
    assign dmemWEN   = wen_q;
    assign dmemaddr  = addr_q;
    assign dmemstore = store_q;
    assign load_data = load_q;
    assign dhit_out  = hit_out_q;
    assign mem_busy  = busy_q;
    assign req_err   = err_q;

endmodule
